// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: run/load controls and BCD time outputs of the timekeeping core
interface bcd_time_counter_if;
  logic       run;
  logic       set_en;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_pm;
  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic [3:0] hr_lo;
  logic [3:0] hr_hi;
  logic       tick_1hz;
  logic       load_err;
  logic       pm;
  modport master (
    output run, set_en, set_hh, set_mm, set_ss, set_pm,
    input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, tick_1hz, load_err, pm
  );
  modport slave (
    input  run, set_en, set_hh, set_mm, set_ss, set_pm,
    output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, tick_1hz, load_err, pm
  );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz prescaler plus BCD hh:mm:ss counter with validated load; HOUR12_EN selects 12-hour AM/PM mode
module bcd_time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  bcd_time_counter_if.slave bus
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
`ifdef HOUR12_EN
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam logic [7:0] HR_RST = 8'h00;
`endif
  logic [PW-1:0] pre;
  logic [3:0] s0, s1, m0, m1, n_s0, n_s1, n_m0, n_m1;
  logic [7:0] hr, n_hr;
  logic pm_q, n_pm, ld_pm, tick, err, ok, term, sc, mc, hc;
  assign term = pre == TERM;
  // Load validation: BCD nibbles, seconds/minutes <= 59, hours in range for the mode
  always_comb begin
    ok = bus.set_hh[3:0] <= 4'd9 && bus.set_hh[7:4] <= 4'd9 &&
         bus.set_mm[3:0] <= 4'd9 && bus.set_mm[7:4] <= 4'd5 &&
         bus.set_ss[3:0] <= 4'd9 && bus.set_ss[7:4] <= 4'd5 &&
`ifdef HOUR12_EN
         bus.set_hh != 8'h00 && bus.set_hh <= 8'h12;
    ld_pm = bus.set_pm;
`else
         bus.set_hh <= 8'h23;
    ld_pm = 1'b0;
`endif
  end
  // One-second advance with the full carry chain resolved in a single edge
  always_comb begin
    sc = s0 == 4'd9;
    mc = sc && s1 == 4'd5;
    hc = mc && m0 == 4'd9 && m1 == 4'd5;
    n_s0 = sc ? 4'd0 : s0 + 4'd1;
    n_s1 = mc ? 4'd0 : sc ? s1 + 4'd1 : s1;
    n_m0 = mc ? (m0 == 4'd9 ? 4'd0 : m0 + 4'd1) : m0;
    n_m1 = hc ? 4'd0 : (mc && m0 == 4'd9) ? m1 + 4'd1 : m1;
`ifdef HOUR12_EN
    n_hr = !hc ? hr : hr == 8'h12 ? 8'h01 : hr == 8'h11 ? 8'h12 :
           hr[3:0] == 4'd9 ? {hr[7:4] + 4'd1, 4'd0} : {hr[7:4], hr[3:0] + 4'd1};
    n_pm = pm_q ^ (hc && hr == 8'h11);
`else
    n_hr = !hc ? hr : hr == 8'h23 ? 8'h00 :
           hr[3:0] == 4'd9 ? {hr[7:4] + 4'd1, 4'd0} : {hr[7:4], hr[3:0] + 4'd1};
    n_pm = 1'b0;
`endif
  end
  // Prescaler and time registers: reset, then valid load, then advance on terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      s0   <= 4'd0;
      s1   <= 4'd0;
      m0   <= 4'd0;
      m1   <= 4'd0;
      hr   <= HR_RST;
      pm_q <= 1'b0;
      tick <= 1'b0;
      err  <= 1'b0;
    end else begin
      tick <= 1'b0;
      err  <= bus.set_en && !ok;
      if (bus.set_en && ok) begin
        pre      <= '0;
        {s1, s0} <= bus.set_ss;
        {m1, m0} <= bus.set_mm;
        hr       <= bus.set_hh;
        pm_q     <= ld_pm;
      end else if (bus.run) begin
        pre <= term ? '0 : pre + 1'b1;
        if (term && !bus.set_en) begin
          s0   <= n_s0;
          s1   <= n_s1;
          m0   <= n_m0;
          m1   <= n_m1;
          hr   <= n_hr;
          pm_q <= n_pm;
          tick <= 1'b1;
        end
      end
    end
  end
  assign bus.sec_lo   = s0;
  assign bus.sec_hi   = s1;
  assign bus.min_lo   = m0;
  assign bus.min_hi   = m1;
  assign bus.hr_lo    = hr[3:0];
  assign bus.hr_hi    = hr[7:4];
  assign bus.tick_1hz = tick;
  assign bus.load_err = err;
  assign bus.pm       = pm_q;
endmodule
